// File: rtl/inst_fetch_if.sv
// ============================================================================
// Module   : inst_fetch_if
// Purpose  : Groups the instruction fetch unit's bus signals into one bundle:
//            the PC handshake, the memory read-address and read-data
//            channels, and the handshake to decode.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Modports:
//   master - the fetch unit's side. It receives pc/pc_if_valid, arready,
//            rdata/rresp/rvalid and id_ready, and it drives everything else.
//   slave  - the side seen by the PC register, memory and decode (the
//            environment).
// Signals:
//   pc, pc_if_valid, if_ready          : PC -> fetch handshake
//   araddr, arvalid, arready           : read-address channel
//   rdata, rresp, rvalid, rready       : read-data channel
//   inst, inst_pc, inst_fault          : fetched word to decode
//   id_valid, id_ready                 : fetch -> decode handshake
// ============================================================================
`default_nettype none

interface inst_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] pc;
  logic              pc_if_valid;
  logic              if_ready;

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;

  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_fault;
  logic              id_valid;
  logic              id_ready;

  modport master (
    input  pc, pc_if_valid, arready, rdata, rresp, rvalid, id_ready,
    output if_ready, araddr, arvalid, rready, inst, inst_pc, inst_fault, id_valid
  );

  modport slave (
    output pc, pc_if_valid, arready, rdata, rresp, rvalid, id_ready,
    input  if_ready, araddr, arvalid, rready, inst, inst_pc, inst_fault, id_valid
  );
endinterface

`default_nettype wire

// File: rtl/inst_fetch.sv
// ============================================================================
// Module   : inst_fetch
// Purpose  : Single-outstanding instruction fetch unit. It accepts a PC and
//            issues one read on the instruction-memory channel. It then
//            returns the fetched word, with its address and a fault flag,
//            to decode.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : inst_fetch_if.master (PC handshake, AR/R channels, decode handshake)
// Parameters:
//   ADDR_W : instruction address width (default 32)
//   DATA_W : instruction word width    (default 32)
// Build option:
//   IFU_ACCESS_FAULT_EN : when defined, a misaligned PC (pc[1:0] != 0) or a
//   read response with rresp != 0 returns a NOP (addi x0,x0,0) with
//   inst_fault=1. A misaligned PC issues no memory read. When the macro is
//   undefined, inst_fault is tied to 0 and rresp is not used.
// ============================================================================
`default_nettype none

module inst_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  wire logic    clk,
  input  wire logic    rst,
  inst_fetch_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_if_ready;
  logic              r_arvalid;
  logic              r_rready;
  logic              r_id_valid;
  logic [ADDR_W-1:0] r_araddr;
  logic [ADDR_W-1:0] r_inst_pc;
  logic [DATA_W-1:0] r_inst;

`ifdef IFU_ACCESS_FAULT_EN
  localparam logic [DATA_W-1:0] c_NOP_INST = DATA_W'(32'h0000_0013);

  logic r_inst_fault;
  logic w_pc_misaligned;
  logic w_rd_error;

  assign w_pc_misaligned = (bus.pc[1:0] != 2'b00);
  assign w_rd_error      = (bus.rresp != 2'b00);
  assign bus.inst_fault  = r_inst_fault;
`else
  // The response code has no meaning without fault reporting.
  logic w_unused;
  assign w_unused       = ^bus.rresp;
  assign bus.inst_fault = 1'b0;
`endif

  // Every output comes straight from a register. Each state arc updates the
  // outputs together with the state, so the outputs always match the state
  // being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_if_ready   <= 1'b1;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_id_valid   <= 1'b0;
      r_araddr     <= '0;
      r_inst_pc    <= '0;
      r_inst       <= '0;
`ifdef IFU_ACCESS_FAULT_EN
      r_inst_fault <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          // if_ready is high in IDLE, so pc_if_valid alone completes the
          // handshake.
          if (bus.pc_if_valid) begin
            r_inst_pc  <= bus.pc;
            r_if_ready <= 1'b0;
`ifdef IFU_ACCESS_FAULT_EN
            if (w_pc_misaligned) begin
              // Misaligned PC: no memory access. Hand a faulting NOP
              // straight to decode.
              r_inst       <= c_NOP_INST;
              r_inst_fault <= 1'b1;
              r_id_valid   <= 1'b1;
              r_state      <= OUT;
            end else begin
              r_inst_fault <= 1'b0;
              r_araddr     <= bus.pc;
              r_arvalid    <= 1'b1;
              r_state      <= ADDR;
            end
`else
            r_araddr  <= bus.pc;
            r_arvalid <= 1'b1;
            r_state   <= ADDR;
`endif
          end
        end

        ADDR: begin
          if (bus.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= DATA;
          end
        end

        DATA: begin
          if (bus.rvalid) begin
`ifdef IFU_ACCESS_FAULT_EN
            r_inst       <= w_rd_error ? c_NOP_INST : bus.rdata;
            r_inst_fault <= w_rd_error;
`else
            r_inst       <= bus.rdata;
`endif
            r_rready   <= 1'b0;
            r_id_valid <= 1'b1;
            r_state    <= OUT;
          end
        end

        OUT: begin
          if (bus.id_ready) begin
            r_id_valid <= 1'b0;
            r_if_ready <= 1'b1;
            r_state    <= IDLE;
          end
        end

        default: begin
          r_state    <= IDLE;
          r_if_ready <= 1'b1;
          r_arvalid  <= 1'b0;
          r_rready   <= 1'b0;
          r_id_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.if_ready = r_if_ready;
  assign bus.arvalid  = r_arvalid;
  assign bus.araddr   = r_araddr;
  assign bus.rready   = r_rready;
  assign bus.id_valid = r_id_valid;
  assign bus.inst     = r_inst;
  assign bus.inst_pc  = r_inst_pc;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ============================================================================
// Module   : tb_inst_fetch
// Purpose  : Self-checking bench for inst_fetch. Directed scenarios cover
//            reset, minimum latency, channel stalls, decode backpressure,
//            asynchronous reset and fault handling. A randomized transaction
//            stream is checked against a per-transaction reference model
//            (expected word, address, fault flag and per-phase durations).
// Revision : 1.0 - initial release
// Build option: IFU_ACCESS_FAULT_EN selects the fault-reporting expectations.
// ============================================================================
`default_nettype none

module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  inst_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  inst_fetch #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Advance one cycle. Outputs are then sampled and inputs driven 1ns after
  // the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pc          = '0;
    bus.pc_if_valid = 1'b0;
    bus.arready     = 1'b0;
    bus.rdata       = '0;
    bus.rresp       = 2'b00;
    bus.rvalid      = 1'b0;
    bus.id_ready    = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2; // before the first clock edge: reset must act without clk
    checks++; if (bus.if_ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready got=%0h exp=1", bus.if_ready); end
    checks++; if ({bus.arvalid, bus.rready, bus.id_valid} !== 3'b000) begin errors++; $display("FAIL reset_valids got=%03b exp=000", {bus.arvalid, bus.rready, bus.id_valid}); end
    checks++; if (bus.araddr !== 32'h0) begin errors++; $display("FAIL reset_araddr got=%08h exp=0", bus.araddr); end
    checks++; if (bus.inst !== 32'h0) begin errors++; $display("FAIL reset_inst got=%08h exp=0", bus.inst); end
    checks++; if (bus.inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc got=%08h exp=0", bus.inst_pc); end
    checks++; if (bus.inst_fault !== 1'b0) begin errors++; $display("FAIL reset_inst_fault got=%0h exp=0", bus.inst_fault); end
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.if_ready !== 1'b1) begin errors++; $display("FAIL reset_release_if_ready got=%0h exp=1", bus.if_ready); end
  endtask

  task automatic test_min_latency();
    bus.pc = 32'h8000_0000; bus.pc_if_valid = 1'b1;
    bus.arready = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'h0010_0093; bus.id_ready = 1'b1;
    checks++; if (bus.if_ready !== 1'b1) begin errors++; $display("FAIL lat_if_ready got=%0h exp=1", bus.if_ready); end
    tick(); // accept edge
    bus.pc_if_valid = 1'b0; bus.pc = 32'h1234_5678;
    checks++; if ({bus.arvalid, bus.id_valid, bus.if_ready} !== 3'b100 || bus.araddr !== 32'h8000_0000) begin errors++; $display("FAIL lat_addr_phase got=%03b/%08h exp=100/80000000", {bus.arvalid, bus.id_valid, bus.if_ready}, bus.araddr); end
    tick();
    checks++; if ({bus.rready, bus.arvalid, bus.id_valid} !== 3'b100) begin errors++; $display("FAIL lat_data_phase got=%03b exp=100", {bus.rready, bus.arvalid, bus.id_valid}); end
    tick(); // third cycle after accept
    checks++; if (bus.id_valid !== 1'b1) begin errors++; $display("FAIL lat_id_valid got=%0h exp=1", bus.id_valid); end
    checks++; if (bus.inst !== 32'h0010_0093 || bus.inst_pc !== 32'h8000_0000 || bus.inst_fault !== 1'b0) begin errors++; $display("FAIL lat_out got=%08h/%08h/%0h exp=00100093/80000000/0", bus.inst, bus.inst_pc, bus.inst_fault); end
    tick();
    checks++; if (bus.if_ready !== 1'b1 || bus.id_valid !== 1'b0) begin errors++; $display("FAIL lat_back_idle got=%0h/%0h exp=1/0", bus.if_ready, bus.id_valid); end
    idle_inputs();
    tick();
  endtask

  task automatic test_channel_stall();
    bus.pc = 32'h0000_1000; bus.pc_if_valid = 1'b1;
    tick();
    bus.pc_if_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h0000_1000 || bus.rready !== 1'b0) begin errors++; $display("FAIL stall_ar_%0d got=%0h/%08h/%0h exp=1/00001000/0", i, bus.arvalid, bus.araddr, bus.rready); end
      tick();
    end
    bus.arready = 1'b1;
    checks++; if (bus.arvalid !== 1'b1) begin errors++; $display("FAIL stall_ar_final got=%0h exp=1", bus.arvalid); end
    tick();
    bus.arready = 1'b0; bus.rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      checks++; if ({bus.rready, bus.arvalid, bus.id_valid} !== 3'b100 || bus.inst !== 32'h0010_0093) begin errors++; $display("FAIL stall_r_%0d got=%03b/%08h exp=100/00100093", i, {bus.rready, bus.arvalid, bus.id_valid}, bus.inst); end
      tick();
    end
    bus.rvalid = 1'b1; bus.rdata = 32'h0020_8113;
    tick();
    bus.rvalid = 1'b0; bus.rdata = 32'hDEAD_BEEF;
    checks++; if (bus.id_valid !== 1'b1 || bus.rready !== 1'b0 || bus.inst !== 32'h0020_8113) begin errors++; $display("FAIL stall_out got=%0h/%0h/%08h exp=1/0/00208113", bus.id_valid, bus.rready, bus.inst); end
    bus.id_ready = 1'b1;
    tick();
    bus.id_ready = 1'b0;
    checks++; if (bus.if_ready !== 1'b1) begin errors++; $display("FAIL stall_back_idle got=%0h exp=1", bus.if_ready); end
    idle_inputs();
  endtask

  task automatic test_decode_backpressure();
    bus.pc = 32'h0000_2000; bus.pc_if_valid = 1'b1;
    bus.arready = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'h0030_0193;
    tick();
    bus.pc_if_valid = 1'b0;
    tick();
    tick(); // now in the output phase
    bus.rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.pc_if_valid = ~bus.pc_if_valid;
      bus.pc = $urandom;
      checks++; if (bus.id_valid !== 1'b1 || bus.inst !== 32'h0030_0193 || bus.inst_pc !== 32'h0000_2000 || bus.if_ready !== 1'b0 || bus.arvalid !== 1'b0) begin errors++; $display("FAIL bp_hold_%0d got=%0h/%08h/%08h/%0h/%0h exp=1/00300193/00002000/0/0", i, bus.id_valid, bus.inst, bus.inst_pc, bus.if_ready, bus.arvalid); end
      tick();
    end
    bus.pc_if_valid = 1'b0; bus.id_ready = 1'b1;
    tick();
    bus.id_ready = 1'b0;
    checks++; if (bus.if_ready !== 1'b1 || bus.id_valid !== 1'b0 || bus.arvalid !== 1'b0) begin errors++; $display("FAIL bp_release got=%0h/%0h/%0h exp=1/0/0", bus.if_ready, bus.id_valid, bus.arvalid); end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    bus.pc = 32'h0000_3000; bus.pc_if_valid = 1'b1; bus.arready = 1'b1;
    tick();
    bus.pc_if_valid = 1'b0;
    tick(); // now waiting for read data
    checks++; if (bus.rready !== 1'b1) begin errors++; $display("FAIL arst_in_data got=%0h exp=1", bus.rready); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({bus.arvalid, bus.rready, bus.id_valid, bus.if_ready} !== 4'b0001) begin errors++; $display("FAIL arst_outputs got=%04b exp=0001", {bus.arvalid, bus.rready, bus.id_valid, bus.if_ready}); end
    checks++; if (bus.inst_pc !== 32'h0 || bus.araddr !== 32'h0) begin errors++; $display("FAIL arst_regs got=%08h/%08h exp=0/0", bus.inst_pc, bus.araddr); end
    #1 rst = 1'b0;
    bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({bus.id_valid, bus.rready, bus.if_ready} !== 3'b001 || bus.inst !== 32'h0) begin errors++; $display("FAIL arst_late_rvalid_%0d got=%03b/%08h exp=001/0", i, {bus.id_valid, bus.rready, bus.if_ready}, bus.inst); end
    end
    idle_inputs();
  endtask

  task automatic test_fault();
    logic [31:0] exp_inst;
    logic        exp_fault;
    bus.pc = 32'h8000_0002; bus.pc_if_valid = 1'b1;
    bus.arready = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'h0000_1111;
    tick();
    bus.pc_if_valid = 1'b0;
`ifdef IFU_ACCESS_FAULT_EN
    checks++; if (bus.arvalid !== 1'b0 || bus.id_valid !== 1'b1 || bus.inst !== NOP || bus.inst_fault !== 1'b1 || bus.inst_pc !== 32'h8000_0002) begin errors++; $display("FAIL fault_misaligned got=%0h/%0h/%08h/%0h/%08h exp=0/1/00000013/1/80000002", bus.arvalid, bus.id_valid, bus.inst, bus.inst_fault, bus.inst_pc); end
`else
    checks++; if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h8000_0002) begin errors++; $display("FAIL nofault_misaligned_ar got=%0h/%08h exp=1/80000002", bus.arvalid, bus.araddr); end
    tick();
    tick();
    checks++; if (bus.id_valid !== 1'b1 || bus.inst !== 32'h0000_1111 || bus.inst_fault !== 1'b0) begin errors++; $display("FAIL nofault_misaligned_out got=%0h/%08h/%0h exp=1/00001111/0", bus.id_valid, bus.inst, bus.inst_fault); end
`endif
    bus.id_ready = 1'b1;
    tick();
    bus.id_ready = 1'b0;
    // Read that returns an error response.
    bus.pc = 32'h0000_4000; bus.pc_if_valid = 1'b1;
    bus.rdata = 32'h0000_ABCD; bus.rresp = 2'b10;
`ifdef IFU_ACCESS_FAULT_EN
    exp_inst = NOP;        exp_fault = 1'b1;
`else
    exp_inst = 32'h0000_ABCD; exp_fault = 1'b0;
`endif
    tick();
    bus.pc_if_valid = 1'b0;
    tick();
    tick();
    checks++; if (bus.id_valid !== 1'b1 || bus.inst !== exp_inst || bus.inst_fault !== exp_fault) begin errors++; $display("FAIL fault_rresp got=%0h/%08h/%0h exp=1/%08h/%0h", bus.id_valid, bus.inst, bus.inst_fault, exp_inst, exp_fault); end
    bus.id_ready = 1'b1;
    tick();
    idle_inputs();
  endtask

  // Random transactions. The reference model works per transaction: from
  // the PC, data and response it derives the word, address and fault flag
  // decode must see. It also decides whether a memory read happens at all.
  // The memory and decode sides insert random delays and drive noise on
  // inputs that must be ignored in each phase.
  task automatic test_random();
    for (int t = 0; t < 60; t++) begin
      logic [31:0] pc, data, exp_inst;
      logic [1:0]  resp;
      logic        exp_fault, has_read;
      int          n_idle, d_ar, d_r, d_id;
      pc = $urandom;
      if ($urandom_range(0, 2) != 0) pc[1:0] = 2'b00;
      data   = $urandom;
      resp   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      n_idle = $urandom_range(0, 2);
      d_ar   = $urandom_range(0, 3);
      d_r    = $urandom_range(0, 3);
      d_id   = $urandom_range(0, 3);
      has_read = 1'b1; exp_inst = data; exp_fault = 1'b0;
`ifdef IFU_ACCESS_FAULT_EN
      if (pc[1:0] != 2'b00) begin
        has_read = 1'b0; exp_inst = NOP; exp_fault = 1'b1;
      end else if (resp != 2'b00) begin
        exp_inst = NOP; exp_fault = 1'b1;
      end
`endif
      for (int k = 0; k < n_idle; k++) begin
        bus.rvalid = 1'($urandom); bus.arready = 1'($urandom);
        checks++; if (bus.if_ready !== 1'b1 || {bus.arvalid, bus.rready, bus.id_valid} !== 3'b000) begin errors++; $display("FAIL rnd%0d_idle got=%0h/%03b exp=1/000", t, bus.if_ready, {bus.arvalid, bus.rready, bus.id_valid}); end
        tick();
      end
      bus.pc = pc; bus.pc_if_valid = 1'b1;
      checks++; if (bus.if_ready !== 1'b1) begin errors++; $display("FAIL rnd%0d_accept got=%0h exp=1", t, bus.if_ready); end
      tick();
      if (has_read) begin
        for (int k = 0; k <= d_ar; k++) begin
          bus.pc = $urandom; bus.pc_if_valid = 1'($urandom);
          bus.arready = (k == d_ar); bus.rvalid = 1'($urandom); bus.rdata = $urandom;
          checks++; if ({bus.arvalid, bus.rready, bus.id_valid, bus.if_ready} !== 4'b1000 || bus.araddr !== pc) begin errors++; $display("FAIL rnd%0d_addr got=%04b/%08h exp=1000/%08h", t, {bus.arvalid, bus.rready, bus.id_valid, bus.if_ready}, bus.araddr, pc); end
          tick();
        end
        for (int k = 0; k <= d_r; k++) begin
          bus.pc_if_valid = 1'($urandom); bus.arready = 1'($urandom);
          bus.rvalid = (k == d_r);
          bus.rdata  = (k == d_r) ? data : $urandom;
          bus.rresp  = (k == d_r) ? resp : 2'($urandom);
          checks++; if ({bus.arvalid, bus.rready, bus.id_valid, bus.if_ready} !== 4'b0100) begin errors++; $display("FAIL rnd%0d_data got=%04b exp=0100", t, {bus.arvalid, bus.rready, bus.id_valid, bus.if_ready}); end
          tick();
        end
      end
      for (int k = 0; k <= d_id; k++) begin
        bus.pc_if_valid = 1'($urandom); bus.arready = 1'($urandom); bus.rvalid = 1'($urandom);
        bus.rdata = $urandom; bus.id_ready = (k == d_id);
        checks++; if ({bus.arvalid, bus.rready, bus.id_valid, bus.if_ready} !== 4'b0010) begin errors++; $display("FAIL rnd%0d_out_ctl got=%04b exp=0010", t, {bus.arvalid, bus.rready, bus.id_valid, bus.if_ready}); end
        checks++; if (bus.inst !== exp_inst || bus.inst_pc !== pc || bus.inst_fault !== exp_fault) begin errors++; $display("FAIL rnd%0d_out_data got=%08h/%08h/%0h exp=%08h/%08h/%0h", t, bus.inst, bus.inst_pc, bus.inst_fault, exp_inst, pc, exp_fault); end
        tick();
      end
      idle_inputs();
    end
  endtask

  initial begin
    test_reset();
    test_min_latency();
    test_channel_stall();
    test_decode_backpressure();
    test_async_reset();
    test_fault();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
